// File: rtl/digit_template_matcher.sv
// rtl/digit_template_matcher.sv - scores a 16x16 drawing against digit templates by pixel agreement
// Reports the best-scoring template index, or 4'hF when no score reaches MIN_SCORE.
module digit_template_matcher #(
    parameter int         NUM_TMPL  = 10,
    parameter logic [8:0] MIN_SCORE = 9'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  tmpl_sel,
    output logic [3:0]  row_addr,
    input  logic [0:15] tmpl_row,
    input  logic [0:15] img_row,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic [8:0]  best_score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAST_TMPL = 4'(NUM_TMPL - 1);
    localparam logic [3:0] LAST_ROW  = 4'd15;
    localparam logic [3:0] NO_MATCH  = 4'hF;

    logic [1:0] state;
    logic [8:0] acc;
    logic [8:0] best;
    logic [3:0] best_idx;
    logic [4:0] row_pop;
    logic [8:0] total;

    // Agreeing pixels in the current row: 1 wherever template and drawing are equal.
    always_comb begin
        row_pop = '0;
        for (int i = 0; i < 16; i++) begin
            row_pop = row_pop + {4'd0, ~(tmpl_row[i] ^ img_row[i])};
        end
    end

    assign total = acc + {4'd0, row_pop};
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tmpl_sel   <= '0;
            row_addr   <= '0;
            acc        <= '0;
            best       <= '0;
            best_idx   <= NO_MATCH;
            digit      <= NO_MATCH;
            best_score <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SCAN;
                        tmpl_sel <= '0;
                        row_addr <= '0;
                        acc      <= '0;
                        best     <= '0;
                        best_idx <= NO_MATCH;
                    end
                end
                S_SCAN: begin
                    if (row_addr == LAST_ROW) begin
                        // Strict compare so a tie keeps the earlier (lower) template.
                        if (total > best) begin
                            best     <= total;
                            best_idx <= tmpl_sel;
                        end
                        acc      <= '0;
                        row_addr <= '0;
                        if (tmpl_sel == LAST_TMPL) begin
                            tmpl_sel <= '0;
                            state    <= S_DONE;
                        end else begin
                            tmpl_sel <= tmpl_sel + 4'd1;
                        end
                    end else begin
                        acc      <= total;
                        row_addr <= row_addr + 4'd1;
                    end
                end
                S_DONE: begin
                    best_score <= best;
                    digit      <= (best >= MIN_SCORE) ? best_idx : NO_MATCH;
                    tmpl_sel   <= '0;
                    row_addr   <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_template_matcher.sv
// tb/tb_digit_template_matcher.sv - scoreboard bench for digit_template_matcher
module tb_digit_template_matcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  tmpl_sel;
    logic [3:0]  row_addr;
    logic [0:15] tmpl_row;
    logic [0:15] img_row;
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [8:0]  best_score;

    logic [15:0] tm  [10][16];
    logic [15:0] img [16];

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q [$];

    always #5 clk = ~clk;

    assign tmpl_row = (tmpl_sel < 4'd10) ? tm[tmpl_sel][row_addr] : 16'h0000;
    assign img_row  = img[row_addr];

    digit_template_matcher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tmpl_sel   (tmpl_sel),
        .row_addr   (row_addr),
        .tmpl_row   (tmpl_row),
        .img_row    (img_row),
        .busy       (busy),
        .done       (done),
        .digit      (digit),
        .best_score (best_score)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count agreeing pixels over the whole 256-pixel image for each template.
    function automatic logic [12:0] model();
        int best = 0;
        int idx = 15;
        for (int t = 0; t < 10; t++) begin
            int s = 0;
            for (int r = 0; r < 16; r++) s += 16 - $countones(tm[t][r] ^ img[r]);
            if (s > best) begin
                best = s;
                idx = t;
            end
        end
        if (best < 200) idx = 15;
        return {4'(idx), 9'(best)};
    endfunction

    // Monitor: result registers update at the edge that ends the done cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: digit %0d score %0d with empty queue", digit, best_score);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    if ({digit, best_score} != e) begin
                        errors++;
                        $display("FAIL result: digit %0d score %0d expected digit %0d score %0d",
                                 digit, best_score, e[12:9], e[8:0]);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_tmpl_sel"}, int'(tmpl_sel), 0);
        chk({tag, "_row_addr"}, int'(row_addr), 0);
        chk({tag, "_digit"}, int'(digit), 15);
        chk({tag, "_best_score"}, int'(best_score), 0);
    endtask

    task automatic run_pass(input bit repulse, input int abort_at);
        int busy_cnt = 0;
        int dones = 0;
        int done_at = 0;
        int sweep_err = 0;
        exp_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                void'(exp_q.pop_back());
                check_reset_state("abort");
                repeat (200) @(negedge clk);
                chk("abort_no_done_queue", exp_q.size(), 0);
                return;
            end
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                dones++;
                done_at = c;
            end
            if (c <= 160 && (int'(tmpl_sel) != (c - 1) / 16 || int'(row_addr) != (c - 1) % 16))
                sweep_err++;
            if (repulse && (c == 20 || c == 100)) start = 1'b1;
        end
        chk("busy_cycles", busy_cnt, 161);
        chk("done_count", dones, 1);
        chk("done_position", done_at, 161);
        chk("address_sweep_errors", sweep_err, 0);
    endtask

    task automatic fill_random_templates();
        for (int t = 0; t < 10; t++)
            for (int r = 0; r < 16; r++) tm[t][r] = 16'($urandom);
    endtask

    initial begin
        for (int t = 0; t < 10; t++)
            for (int r = 0; r < 16; r++) tm[t][r] = '0;
        for (int r = 0; r < 16; r++) img[r] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Exact copy of template 7
        fill_random_templates();
        for (int r = 0; r < 16; r++) img[r] = tm[7][r];
        run_pass(1'b0, 0);

        // Tie between templates 3 and 5
        for (int t = 0; t < 10; t++)
            for (int r = 0; r < 16; r++) tm[t][r] = '0;
        for (int r = 0; r < 16; r++) begin
            img[r] = 16'($urandom);
            tm[3][r] = img[r];
            tm[5][r] = img[r];
        end
        run_pass(1'b0, 0);

        // All-zero templates against all-ones image
        for (int t = 0; t < 10; t++)
            for (int r = 0; r < 16; r++) tm[t][r] = '0;
        for (int r = 0; r < 16; r++) img[r] = 16'hFFFF;
        run_pass(1'b0, 0);

        // Exactly 60 zero pixels: score 60, below threshold
        for (int p = 0; p < 60; p++) img[(p * 4) / 16][(p * 4) % 16] = 1'b0;
        run_pass(1'b0, 0);

        // Template 2 with 40 flipped pixels, with start re-pulsed mid-pass
        fill_random_templates();
        for (int r = 0; r < 16; r++) img[r] = tm[2][r];
        for (int p = 0; p < 40; p++) img[(p * 6) / 16][(p * 6) % 16] = ~img[(p * 6) / 16][(p * 6) % 16];
        run_pass(1'b1, 0);

        // Abort at SCAN cycle 50, then a fresh pass
        run_pass(1'b0, 50);
        run_pass(1'b0, 0);

        // Randomized passes: noisy copies of a random template
        for (int k = 0; k < 5; k++) begin
            int src;
            int flips;
            fill_random_templates();
            src = int'($urandom_range(9, 0));
            flips = int'($urandom_range(80, 0));
            for (int r = 0; r < 16; r++) img[r] = tm[src][r];
            for (int f = 0; f < flips; f++) begin
                int p;
                p = int'($urandom_range(255, 0));
                img[p / 16][p % 16] = ~img[p / 16][p % 16];
            end
            run_pass(1'b0, 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_template_matcher.md
Name: digit_template_matcher

Overview:
- Downstream consumer of the per-digit 16x16 character ROMs (one row of 16 pixels per 4-bit address, combinational read) and of the user drawing buffer.
- On a start pulse, scans all NUM_TMPL templates row by row and scores each against the drawn image by pixel agreement (XNOR popcount).
- Reports the best-matching digit and its score to the display/control logic.

Parameters:
- NUM_TMPL, 10, number of digit templates; template index 0..NUM_TMPL-1 equals the digit value.
- MIN_SCORE, 9'd200, minimum winning score for a valid recognition; below this the result is "no match".

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a recognition pass
- tmpl_sel  output  4  template index driven to the external ROM mux
- row_addr  output  4  row address, shared by ROM mux and drawing buffer
- tmpl_row  input  [0:15]  template row returned combinationally for (tmpl_sel, row_addr)
- img_row  input  [0:15]  drawn-image row returned combinationally for row_addr
- busy  output  1  high while a pass is in progress
- done  output  1  one-cycle pulse when result is updated
- digit  output  4  recognised digit 0..9, or 4'hF for no match
- best_score  output  9  agreeing-pixel count of winner, 0..256

Behaviour:
- Reset (synchronous, rst high at a clk edge): state IDLE; tmpl_sel=0, row_addr=0, busy=0, done=0, digit=4'hF, best_score=0; internal accumulator and best registers cleared. Reset overrides start and aborts a pass in progress with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: busy=0. start sampled high -> SCAN with tmpl_sel=0, row_addr=0, acc=0, best=0, best_idx=4'hF.
- SCAN: busy=1. Each cycle:
  - row_pop = popcount(~(tmpl_row ^ img_row)), range 0..16.
  - Rows 0..14: acc <= acc + row_pop; row_addr increments.
  - Row 15: total = acc + row_pop (9 bits, max 256, no overflow).
    - If total > best (strict), best <= total and best_idx <= tmpl_sel. Ties keep the lower index.
    - acc <= 0, row_addr <= 0, tmpl_sel increments.
    - If tmpl_sel == NUM_TMPL-1 -> DONE.
- DONE (one cycle):
  - done=1, busy=1.
  - best_score <= best.
  - digit <= (best >= MIN_SCORE) ? best_idx : 4'hF.
  - Outputs visible from the cycle after DONE and held until the next done or reset.
  - Next state IDLE; tmpl_sel and row_addr return to 0.
- Latency: pass of NUM_TMPL*16 = 160 SCAN cycles. done is high during the cycle following the 160th SCAN edge, i.e. 161 edges after the edge that sampled start. Updated digit and best_score are valid at the edge ending the done cycle.
- start while busy (SCAN or DONE) is ignored, not queued.
- start held high continuously: a new pass begins on the first IDLE cycle after DONE.
- Inputs tmpl_row and img_row are sampled in the same cycle as the addresses they respond to (combinational sources); no extra pipeline stage.
- All arithmetic unsigned; popcount is a 5-bit result, accumulator and best are 9 bits.

Test Plan:
- Bench ROMs hold ten distinct digit bitmaps; image is an exact copy of template 7; pulse start -> busy high for 161 cycles, single done pulse, digit=7, best_score=256.
- Templates 3 and 5 both identical to the image, all others all-zero -> digit=3, best_score=256 (tie keeps lower index).
- All templates all-zero, image all-ones -> every total 0; digit=4'hF, best_score=0. Then image with exactly 60 zero pixels vs all-zero templates -> best_score=60 < MIN_SCORE -> digit=4'hF.
- Image matches template 2 except 40 flipped pixels -> best_score=216, digit=2. Verify row_addr sweeps 0..15 per template and tmpl_sel sweeps 0..9 exactly once each.
- start re-pulsed at cycle 20 and cycle 100 of a pass -> ignored; exactly one done, 161 edges after the first start.
- rst asserted at SCAN cycle 50 -> next edge IDLE, all outputs at reset values, no done. A fresh start then completes normally with the correct digit.
